io_interp_sel_stepper: RTL and testbench

Parametrised, multi-channel controller for the phase-interpolator 8:1 mux select codes. It accepts a binary target phase per channel through a valid/ready handshake. It then walks the channel's select code one position at a time around the phase ring, in the shortest direction, with a programmable settle time between steps. Each step changes exactly one bit of the registered gray-coded output, so the interpolator mux never sees a multi-bit transition. One instance sits between the DLL/CDR phase-update logic and the interpolator mux bank, and serves NCH interpolators.

---
 rtl/io_interp_pkg.sv | 27 ++
 rtl/io_interp_sel_chan.sv | 110 +++++++++++
 rtl/io_interp_sel_stepper.sv | 41 ++++
 tb/tb_io_interp_sel_stepper.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_interp_pkg.sv
// Shared types and helpers for the phase-interpolator select stepper.
// Helpers work on MaxSelW-wide values; callers zero-extend and truncate.
package io_interp_pkg;

  localparam int unsigned MaxSelW = 16;

  typedef enum logic {StIdle, StSettle} chan_state_e;
  typedef enum logic {DirUp, DirDown} step_dir_e;

  function automatic logic [MaxSelW-1:0] bin2gray(input logic [MaxSelW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Shortest way round the ring; the exact half-ring tie goes up.
  function automatic step_dir_e step_dir(input logic [MaxSelW-1:0] cur,
                                         input logic [MaxSelW-1:0] tgt,
                                         input int unsigned sel_w);
    logic [MaxSelW-1:0] mask;
    logic [MaxSelW-1:0] half;
    logic [MaxSelW-1:0] d;
    mask = (MaxSelW'(1) << sel_w) - MaxSelW'(1);
    half = MaxSelW'(1) << (sel_w - 1);
    d    = (tgt - cur) & mask;
    return (d <= half) ? DirUp : DirDown;
  endfunction

endpackage

// File: rtl/io_interp_sel_chan.sv
// One interpolator channel: walks a registered gray select code one ring
// position at a time towards an accepted target, with a settle gap per step.
module io_interp_sel_chan
  import io_interp_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned RESET_CODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             tgt_valid,
  input  logic [SEL_W-1:0] tgt_bin,
  output logic             tgt_ready,
  output logic [SEL_W-1:0] cur_bin,
  output logic [SEL_W-1:0] mux_sel_gray,
  output logic [SEL_W-1:0] mux_sel_inv,
  output logic             busy,
  output logic             step_pulse
);

  localparam int unsigned     CntW      = $clog2(SETTLE_CYC + 1);
  localparam logic [CntW-1:0] CntLoad   = CntW'(SETTLE_CYC);
  localparam logic [SEL_W-1:0] ResetBin  = SEL_W'(RESET_CODE);
  localparam logic [SEL_W-1:0] ResetGray = SEL_W'(bin2gray(MaxSelW'(ResetBin)));

  chan_state_e      state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [SEL_W-1:0] gray_q, gray_d;
  step_dir_e        dir_q, dir_d, dir_now;
  logic             pulse_q, pulse_d;
  logic             step;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    dir_now = dir_q;
    step    = 1'b0;
    if (!freeze) begin
      case (state_q)
        StIdle: begin
          if (tgt_valid) begin
            tgt_d = tgt_bin;
            if (tgt_bin != cur_q) begin
              // Direction is latched here and held for the whole move.
              dir_now = step_dir(MaxSelW'(cur_q), MaxSelW'(tgt_bin), SEL_W);
              dir_d   = dir_now;
              step    = 1'b1;
              state_d = StSettle;
              cnt_d   = CntLoad;
            end
          end
        end
        StSettle: begin
          if (cnt_q == CntW'(1)) begin
            if (cur_q == tgt_q) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              step  = 1'b1;
              cnt_d = CntLoad;
            end
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: ;
      endcase
    end
    if (step) begin
      cur_d = (dir_now == DirUp) ? cur_q + SEL_W'(1) : cur_q - SEL_W'(1);
    end
    gray_d  = SEL_W'(bin2gray(MaxSelW'(cur_d)));
    pulse_d = step;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cur_q   <= ResetBin;
      tgt_q   <= ResetBin;
      gray_q  <= ResetGray;
      dir_q   <= DirUp;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      gray_q  <= gray_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
    end
  end

  assign tgt_ready    = (state_q == StIdle) & ~freeze;
  assign cur_bin      = cur_q;
  assign mux_sel_gray = gray_q;
  assign mux_sel_inv  = ~gray_q;
  assign busy         = (state_q == StSettle);
  assign step_pulse   = pulse_q;

endmodule

// File: rtl/io_interp_sel_stepper.sv
// NCH independent interpolator select steppers; this level only slices buses.
module io_interp_sel_stepper #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned RESET_CODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 freeze,
  input  logic [NCH-1:0]       tgt_valid,
  input  logic [NCH*SEL_W-1:0] tgt_bin,
  output logic [NCH-1:0]       tgt_ready,
  output logic [NCH*SEL_W-1:0] cur_bin,
  output logic [NCH*SEL_W-1:0] mux_sel_gray,
  output logic [NCH*SEL_W-1:0] mux_sel_inv,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       step_pulse
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    io_interp_sel_chan #(
      .SEL_W     (SEL_W),
      .SETTLE_CYC(SETTLE_CYC),
      .RESET_CODE(RESET_CODE)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .freeze      (freeze),
      .tgt_valid   (tgt_valid[i]),
      .tgt_bin     (tgt_bin[i*SEL_W +: SEL_W]),
      .tgt_ready   (tgt_ready[i]),
      .cur_bin     (cur_bin[i*SEL_W +: SEL_W]),
      .mux_sel_gray(mux_sel_gray[i*SEL_W +: SEL_W]),
      .mux_sel_inv (mux_sel_inv[i*SEL_W +: SEL_W]),
      .busy        (busy[i]),
      .step_pulse  (step_pulse[i])
    );
  end

endmodule

// File: tb/tb_io_interp_sel_stepper.sv
// Directed bench for io_interp_sel_stepper: one DUT with RESET_CODE=0 and one
// with RESET_CODE=2, sharing clock, reset, freeze and target bus.
module tb_io_interp_sel_stepper;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze;
  logic [3:0]  tgt_valid;
  logic [3:0]  tgt_valid2;
  logic [11:0] tgt_bin;

  logic [3:0]  tgt_ready, busy, step_pulse;
  logic [11:0] cur_bin, mux_sel_gray, mux_sel_inv;
  logic [3:0]  tgt_ready2, busy2, step_pulse2;
  logic [11:0] cur_bin2, mux_sel_gray2, mux_sel_inv2;

  int n_assert = 0;
  int n_fail   = 0;
  int pulse_cnt0 = 0;
  int pc;
  logic [2:0] prev_gray;

  always #5 clk = ~clk;

  io_interp_sel_stepper #(
    .NCH(4), .SEL_W(3), .SETTLE_CYC(4), .RESET_CODE(0)
  ) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .tgt_valid(tgt_valid), .tgt_bin(tgt_bin),
    .tgt_ready(tgt_ready), .cur_bin(cur_bin), .mux_sel_gray(mux_sel_gray),
    .mux_sel_inv(mux_sel_inv), .busy(busy), .step_pulse(step_pulse)
  );

  io_interp_sel_stepper #(
    .NCH(4), .SEL_W(3), .SETTLE_CYC(4), .RESET_CODE(2)
  ) dut2 (
    .clk(clk), .reset(reset), .freeze(freeze), .tgt_valid(tgt_valid2), .tgt_bin(tgt_bin),
    .tgt_ready(tgt_ready2), .cur_bin(cur_bin2), .mux_sel_gray(mux_sel_gray2),
    .mux_sel_inv(mux_sel_inv2), .busy(busy2), .step_pulse(step_pulse2)
  );

  always @(negedge clk) if (step_pulse[0]) pulse_cnt0++;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int ch, input logic [2:0] t);
    tgt_bin[ch*3 +: 3] = t;
    tgt_valid[ch] = 1'b1;
    tick(1);
    tgt_valid[ch] = 1'b0;
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b0; tgt_valid = '0; tgt_valid2 = '0; tgt_bin = '0;
    tick(2);
    reset = 1'b0;

    // Reset state
    chk("rst_cur", cur_bin, 12'h000);
    chk("rst_gray", mux_sel_gray, 12'h000);
    chk("rst_inv", mux_sel_inv, 12'hfff);
    chk("rst_busy", {8'h0, busy}, 12'h000);
    chk("rst_pulse", {8'h0, step_pulse}, 12'h000);
    chk("rst_ready", {8'h0, tgt_ready}, 12'h00f);
    chk("rst2_cur", cur_bin2, 12'h492);
    chk("rst2_gray", mux_sel_gray2, 12'h6db);

    // ch0 0 -> 3
    pc = pulse_cnt0;
    req(0, 3'd3);
    chk("m3_t0_cur", {9'h0, cur_bin[2:0]}, 12'd1);
    chk("m3_t0_gray", {9'h0, mux_sel_gray[2:0]}, 12'b001);
    chk("m3_t0_pulse", {8'h0, step_pulse}, 12'b0001);
    chk("m3_t0_busy", {8'h0, busy}, 12'b0001);
    chk("m3_t0_ready", {8'h0, tgt_ready}, 12'b1110);
    tick(3);
    chk("m3_t3_cur", {9'h0, cur_bin[2:0]}, 12'd1);
    chk("m3_t3_pulse", {8'h0, step_pulse}, 12'b0000);
    tick(1);
    chk("m3_t4_cur", {9'h0, cur_bin[2:0]}, 12'd2);
    chk("m3_t4_gray", {9'h0, mux_sel_gray[2:0]}, 12'b011);
    chk("m3_t4_pulse", {8'h0, step_pulse}, 12'b0001);
    tick(4);
    chk("m3_t8_cur", {9'h0, cur_bin[2:0]}, 12'd3);
    chk("m3_t8_gray", {9'h0, mux_sel_gray[2:0]}, 12'b010);
    tick(3);
    chk("m3_t11_busy", {8'h0, busy}, 12'b0001);
    chk("m3_t11_ready", {8'h0, tgt_ready}, 12'b1110);
    tick(1);
    chk("m3_t12_busy", {8'h0, busy}, 12'b0000);
    chk("m3_t12_ready", {8'h0, tgt_ready}, 12'b1111);
    chk("m3_pulses", 12'(pulse_cnt0 - pc), 12'd3);

    // Wrap: 3 -> 1 (down), then 1 -> 6 going down through 0 and 7
    req(0, 3'd1);
    tick(8);
    chk("pre_wrap_cur", {9'h0, cur_bin[2:0]}, 12'd1);
    chk("pre_wrap_busy", {11'h0, busy[0]}, 12'd0);
    prev_gray = mux_sel_gray[2:0];
    req(0, 3'd6);
    chk("wrap_t0_cur", {9'h0, cur_bin[2:0]}, 12'd0);
    chk("wrap_t0_gray", {9'h0, mux_sel_gray[2:0]}, 12'b000);
    chk("wrap_t0_1bit", 12'($countones(mux_sel_gray[2:0] ^ prev_gray)), 12'd1);
    prev_gray = mux_sel_gray[2:0];
    tick(4);
    chk("wrap_t4_cur", {9'h0, cur_bin[2:0]}, 12'd7);
    chk("wrap_t4_gray", {9'h0, mux_sel_gray[2:0]}, 12'b100);
    chk("wrap_t4_1bit", 12'($countones(mux_sel_gray[2:0] ^ prev_gray)), 12'd1);
    prev_gray = mux_sel_gray[2:0];
    tick(4);
    chk("wrap_t8_cur", {9'h0, cur_bin[2:0]}, 12'd6);
    chk("wrap_t8_gray", {9'h0, mux_sel_gray[2:0]}, 12'b101);
    chk("wrap_t8_inv", {9'h0, mux_sel_inv[2:0]}, 12'b010);
    chk("wrap_t8_1bit", 12'($countones(mux_sel_gray[2:0] ^ prev_gray)), 12'd1);
    tick(4);
    chk("wrap_t12_busy", {11'h0, busy[0]}, 12'd0);

    // Tie: 6 -> 0 (up via 7), then 0 -> 4 must go up
    req(0, 3'd0);
    tick(8);
    chk("pre_tie_cur", {9'h0, cur_bin[2:0]}, 12'd0);
    req(0, 3'd4);
    chk("tie_t0_cur", {9'h0, cur_bin[2:0]}, 12'd1);
    tick(4);
    chk("tie_t4_cur", {9'h0, cur_bin[2:0]}, 12'd2);
    tick(4);
    chk("tie_t8_cur", {9'h0, cur_bin[2:0]}, 12'd3);
    tick(4);
    chk("tie_t12_cur", {9'h0, cur_bin[2:0]}, 12'd4);
    chk("tie_t12_gray", {9'h0, mux_sel_gray[2:0]}, 12'b110);
    tick(4);
    chk("tie_t16_ready", {8'h0, tgt_ready}, 12'b1111);

    // Target equal to current
    req(0, 3'd5);
    tick(4);
    chk("pre_eq_cur", {9'h0, cur_bin[2:0]}, 12'd5);
    pc = pulse_cnt0;
    req(0, 3'd5);
    chk("eq_busy", {8'h0, busy}, 12'b0000);
    chk("eq_pulse", {8'h0, step_pulse}, 12'b0000);
    chk("eq_ready", {8'h0, tgt_ready}, 12'b1111);
    tick(1);
    chk("eq_busy2", {8'h0, busy}, 12'b0000);
    chk("eq_cur", {9'h0, cur_bin[2:0]}, 12'd5);
    chk("eq_pulses", 12'(pulse_cnt0 - pc), 12'd0);

    // Freeze for two edges during a 0 -> 2 move
    req(0, 3'd0);
    tick(12);
    chk("pre_frz_cur", {9'h0, cur_bin[2:0]}, 12'd0);
    req(0, 3'd2);
    chk("frz_t0_cur", {9'h0, cur_bin[2:0]}, 12'd1);
    tick(1);
    freeze = 1'b1;
    tgt_bin[11:9] = 3'd5;
    tgt_valid[3] = 1'b1;
    #1;
    chk("frz_ready", {8'h0, tgt_ready}, 12'b0000);
    tick(1);
    chk("frz_t2_cur", {9'h0, cur_bin[2:0]}, 12'd1);
    chk("frz_t2_busy", {8'h0, busy}, 12'b0001);
    tick(1);
    tgt_valid[3] = 1'b0;
    freeze = 1'b0;
    chk("frz_ch3_cur", {9'h0, cur_bin[11:9]}, 12'd0);
    chk("frz_ch3_busy", {11'h0, busy[3]}, 12'd0);
    tick(2);
    chk("frz_t5_cur", {9'h0, cur_bin[2:0]}, 12'd1);
    tick(1);
    chk("frz_t6_cur", {9'h0, cur_bin[2:0]}, 12'd2);
    chk("frz_t6_pulse", {8'h0, step_pulse}, 12'b0001);
    tick(3);
    chk("frz_t9_busy", {11'h0, busy[0]}, 12'd1);
    tick(1);
    chk("frz_t10_busy", {11'h0, busy[0]}, 12'd0);

    // ch1 0 -> 2 and ch2 0 -> 7 accepted together
    tgt_bin[5:3] = 3'd2;
    tgt_bin[8:6] = 3'd7;
    tgt_valid = 4'b0110;
    tick(1);
    tgt_valid = '0;
    chk("par_t0_cur", cur_bin, {3'd0, 3'd7, 3'd1, 3'd2});
    chk("par_t0_busy", {8'h0, busy}, 12'b0110);
    chk("par_t0_pulse", {8'h0, step_pulse}, 12'b0110);
    tick(4);
    chk("par_t4_cur", cur_bin, {3'd0, 3'd7, 3'd2, 3'd2});
    chk("par_t4_busy", {8'h0, busy}, 12'b0010);
    tick(4);
    chk("par_t8_busy", {8'h0, busy}, 12'b0000);
    chk("par_t8_ready", {8'h0, tgt_ready}, 12'b1111);

    // Reset mid-move on the RESET_CODE=2 instance (2 -> 6, tie goes up)
    tgt_bin[2:0] = 3'd6;
    tgt_valid2[0] = 1'b1;
    tick(1);
    tgt_valid2[0] = 1'b0;
    chk("r2_t0_cur", {9'h0, cur_bin2[2:0]}, 12'd3);
    tick(5);
    chk("r2_t5_cur", {9'h0, cur_bin2[2:0]}, 12'd4);
    chk("r2_t5_busy", {11'h0, busy2[0]}, 12'd1);
    reset = 1'b1;
    tgt_bin[2:0] = 3'd3;
    tgt_valid[0] = 1'b1;
    tick(1);
    reset = 1'b0;
    tgt_valid[0] = 1'b0;
    chk("r2_cur", {9'h0, cur_bin2[2:0]}, 12'd2);
    chk("r2_gray", {9'h0, mux_sel_gray2[2:0]}, 12'b011);
    chk("r2_inv", {9'h0, mux_sel_inv2[2:0]}, 12'b100);
    chk("r2_busy", {8'h0, busy2}, 12'b0000);
    chk("r2_ready", {8'h0, tgt_ready2}, 12'b1111);
    chk("r2_pulse", {8'h0, step_pulse2}, 12'b0000);
    chk("r1_cur", cur_bin, 12'h000);
    chk("r1_busy", {8'h0, busy}, 12'b0000);
    tick(1);
    chk("r1_busy_after", {8'h0, busy}, 12'b0000);
    chk("r1_cur_after", cur_bin, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
